// File: rtl/exunit_share_arb_pkg.sv
// Shared widths for the execution-unit sharing arbiter.
// Speculative tags are one-hot; the default tag width matches the rest of the core.
package exunit_share_arb_pkg;

  localparam int SPECTAG_LEN_DEF = 5;
  localparam int ENTSEL_DEF      = 2;

  localparam int NUM_STATIONS = 2;

endpackage

// File: rtl/exunit_share_arb_rr_pick2.sv
// Two-way round-robin picker: lp names the last winner, so the other requester wins a tie.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       lp,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | lp);
  assign gnt[1] = req[1] & (~req[0] | ~lp);

endmodule

// File: rtl/exunit_share_arb.sv
// Shares one non-pipelined, variable-latency execution unit between two in-order
// reservation stations; tracks the single in-flight op and kills it on a mispredict.
module exunit_share_arb
  import exunit_share_arb_pkg::*;
#(
  parameter int ENTSEL      = ENTSEL_DEF,
  parameter int SPECTAG_LEN = SPECTAG_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rdy0,
  input  logic                   rdy1,
  input  logic [ENTSEL-1:0]      ptr0,
  input  logic [ENTSEL-1:0]      ptr1,
  input  logic [SPECTAG_LEN-1:0] spectag0,
  input  logic [SPECTAG_LEN-1:0] spectag1,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] killspecvec,
  input  logic [SPECTAG_LEN-1:0] specfixtag,
  input  logic                   ex_done,
  output logic                   exbusy0,
  output logic                   exbusy1,
  output logic                   ex_start,
  output logic                   ex_abort,
  output logic                   done_valid,
  output logic                   done_src,
  output logic [ENTSEL-1:0]      done_ptr,
  output logic                   inflight
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} arb_state_e;

  arb_state_e             r_state;
  logic                   r_own;
  logic                   r_lp;
  logic [ENTSEL-1:0]      r_hptr;
  logic [SPECTAG_LEN-1:0] r_htag;

  logic                   w_busy;
  logic                   w_kill;
  logic                   w_done;
  logic                   w_free;
  logic [1:0]             w_rdy;
  logic [1:0]             w_req;
  logic [1:0]             w_gnt;
  logic [1:0]             w_issue;
  logic                   w_start;
  logic                   w_isrc;
  logic [ENTSEL-1:0]      w_new_ptr;
  logic [SPECTAG_LEN-1:0] w_new_tag;
  logic [SPECTAG_LEN-1:0] w_fixmask;

  assign w_busy = (r_state == ST_BUSY);
  assign w_kill = w_busy & prmiss & (|(r_htag & killspecvec));
  assign w_done = w_busy & ex_done & ~w_kill;
  assign w_free = ~w_busy | w_done;

  assign w_rdy = {rdy1, rdy0};
  assign w_req = w_rdy & {NUM_STATIONS{w_free}};

  rr_pick2 u_pick (
    .req (w_req),
    .lp  (r_lp),
    .gnt (w_gnt)
  );

  // Stations gate their own issue with prmiss; mirror that so ownership tracking agrees.
  assign w_issue   = w_rdy & w_gnt & {NUM_STATIONS{~prmiss}};
  assign w_start   = |w_issue;
  assign w_isrc    = w_issue[1];
  assign w_new_ptr = w_isrc ? ptr1 : ptr0;
  assign w_new_tag = w_isrc ? spectag1 : spectag0;
  assign w_fixmask = prsuccess ? ~specfixtag : {SPECTAG_LEN{1'b1}};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_own   <= 1'b0;
      r_lp    <= 1'b1;
      r_hptr  <= '0;
      r_htag  <= '0;
    end else if (w_start) begin
      r_state <= ST_BUSY;
      r_own   <= w_isrc;
      r_lp    <= w_isrc;
      r_hptr  <= w_new_ptr;
      r_htag  <= w_new_tag & w_fixmask;
    end else if (w_kill || w_done) begin
      r_state <= ST_IDLE;
    end else if (w_busy) begin
      r_htag  <= r_htag & w_fixmask;
    end
  end

  assign exbusy0    = ~w_gnt[0];
  assign exbusy1    = ~w_gnt[1];
  assign ex_start   = w_start;
  assign ex_abort   = w_kill;
  assign done_valid = w_done;
  assign done_src   = r_own;
  assign done_ptr   = r_hptr;
  assign inflight   = w_busy;

endmodule

// File: tb/tb_exunit_share_arb.sv
// Randomised and directed bench for exunit_share_arb against a behavioural
// model of the one-op-in-flight sharing rules.
module tb_exunit_share_arb;

  localparam int ENTSEL = 2;
  localparam int STL    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             rdy0, rdy1;
  logic [ENTSEL-1:0] ptr0, ptr1;
  logic [STL-1:0]   spectag0, spectag1;
  logic             prmiss, prsuccess;
  logic [STL-1:0]   killspecvec, specfixtag;
  logic             ex_done;
  logic             exbusy0, exbusy1, ex_start, ex_abort, done_valid, done_src, inflight;
  logic [ENTSEL-1:0] done_ptr;

  exunit_share_arb #(.ENTSEL(ENTSEL), .SPECTAG_LEN(STL)) dut (
    .clk(clk), .reset(reset),
    .rdy0(rdy0), .rdy1(rdy1), .ptr0(ptr0), .ptr1(ptr1),
    .spectag0(spectag0), .spectag1(spectag1),
    .prmiss(prmiss), .prsuccess(prsuccess),
    .killspecvec(killspecvec), .specfixtag(specfixtag),
    .ex_done(ex_done),
    .exbusy0(exbusy0), .exbusy1(exbusy1), .ex_start(ex_start), .ex_abort(ex_abort),
    .done_valid(done_valid), .done_src(done_src), .done_ptr(done_ptr), .inflight(inflight)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: at most one op outstanding, described by who owns it and its entry/tag.
  bit       m_busy = 0;
  int       m_own  = 0;
  int       m_ptr  = 0;
  int       m_tag  = 0;
  int       m_last = 1;
  int       e_win;
  bit       e_kill, e_done, e_start;

  task automatic set_idle_inputs();
    reset = 0; rdy0 = 0; rdy1 = 0; ptr0 = '0; ptr1 = '0;
    spectag0 = '0; spectag1 = '0; prmiss = 0; prsuccess = 0;
    killspecvec = '0; specfixtag = '0; ex_done = 0;
  endtask

  // Compare this cycle's combinational outputs with the model (inputs already driven).
  task automatic cyc_check();
    bit r0, r1, can_take;
    #1;
    r0 = rdy0; r1 = rdy1;
    e_kill   = m_busy && prmiss && ((m_tag & int'(killspecvec)) != 0);
    e_done   = m_busy && ex_done && !e_kill;
    can_take = !m_busy || e_done;
    e_win = -1;
    if (can_take) begin
      if (r0 && r1) e_win = (m_last == 0) ? 1 : 0;
      else if (r0)  e_win = 0;
      else if (r1)  e_win = 1;
    end
    e_start = (e_win >= 0) && !prmiss;
    chk("exbusy0",    exbusy0,    (e_win == 0) ? 0 : 1);
    chk("exbusy1",    exbusy1,    (e_win == 1) ? 0 : 1);
    chk("ex_start",   ex_start,   e_start);
    chk("ex_abort",   ex_abort,   e_kill);
    chk("done_valid", done_valid, e_done);
    chk("inflight",   inflight,   m_busy);
    if (e_done) begin
      chk("done_src", done_src, m_own);
      chk("done_ptr", done_ptr, m_ptr);
    end
  endtask

  task automatic cyc_end();
    int keep;
    @(posedge clk);
    keep = prsuccess ? (~int'(specfixtag) & 32'h1f) : 32'h1f;
    if (reset) begin
      m_busy = 0; m_own = 0; m_ptr = 0; m_tag = 0; m_last = 1;
    end else if (e_start) begin
      m_busy = 1;
      m_own  = e_win;
      m_last = e_win;
      m_ptr  = (e_win == 1) ? int'(ptr1) : int'(ptr0);
      m_tag  = ((e_win == 1) ? int'(spectag1) : int'(spectag0)) & keep;
    end else if (e_kill || e_done) begin
      m_busy = 0;
    end else if (m_busy) begin
      m_tag = m_tag & keep;
    end
  endtask

  task automatic cyc();
    cyc_check();
    cyc_end();
  endtask

  task automatic do_reset();
    @(negedge clk); set_idle_inputs(); reset = 1; cyc();
    @(negedge clk); set_idle_inputs(); cyc();
  endtask

  initial begin
    set_idle_inputs();
    reset = 1;
    // Reset state: both stations see busy when nothing is ready.
    @(negedge clk); cyc();
    @(negedge clk); set_idle_inputs(); cyc_check();
    chk("rst_exbusy0", exbusy0, 1); chk("rst_exbusy1", exbusy1, 1);
    chk("rst_inflight", inflight, 0); chk("rst_done", done_valid, 0);
    cyc_end();

    // Solo issue from station 0, done three cycles later.
    @(negedge clk); rdy0 = 1; ptr0 = 2'd2; spectag0 = 5'b00001; cyc_check();
    chk("solo_exbusy0", exbusy0, 0); chk("solo_start", ex_start, 1); cyc_end();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); set_idle_inputs(); cyc_check(); chk("solo_inflight", inflight, 1); cyc_end();
    end
    @(negedge clk); set_idle_inputs(); ex_done = 1; cyc_check();
    chk("solo_inflight3", inflight, 1); chk("solo_done", done_valid, 1);
    chk("solo_src", done_src, 0); chk("solo_ptr", done_ptr, 2); cyc_end();

    // Contention: grants alternate starting with station 0.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); set_idle_inputs(); rdy0 = 1; rdy1 = 1;
      ptr0 = 2'(i); ptr1 = 2'(i + 1); spectag0 = 5'b00010; spectag1 = 5'b00100;
      ex_done = (i % 2 == 0) && (i > 0);
      cyc_check();
      if (i % 2 == 0) begin
        chk("cont_start", ex_start, 1);
        chk("cont_exbusy0", exbusy0, ((i / 2) % 2 == 0) ? 0 : 1);
        chk("cont_exbusy1", exbusy1, ((i / 2) % 2 == 0) ? 1 : 0);
      end
      cyc_end();
    end

    // Kill, and kill coincident with ex_done.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      @(negedge clk); set_idle_inputs(); rdy1 = 1; ptr1 = 2'd3; spectag1 = 5'b00100; cyc();
      @(negedge clk); set_idle_inputs(); rdy0 = 1; rdy1 = 1; prmiss = 1;
      killspecvec = 5'b00110; ex_done = (k == 1);
      cyc_check();
      chk("kill_abort", ex_abort, 1); chk("kill_done", done_valid, 0); chk("kill_nostart", ex_start, 0);
      cyc_end();
      @(negedge clk); set_idle_inputs(); cyc_check(); chk("kill_idle", inflight, 0); cyc_end();
    end

    // Non-hit mispredict, then a fix that clears the tag.
    do_reset();
    @(negedge clk); set_idle_inputs(); rdy0 = 1; ptr0 = 2'd1; spectag0 = 5'b01000; cyc();
    @(negedge clk); set_idle_inputs(); prmiss = 1; killspecvec = 5'b00011; cyc_check();
    chk("nohit_abort", ex_abort, 0); cyc_end();
    @(negedge clk); set_idle_inputs(); ex_done = 1; cyc_check(); chk("nohit_done", done_valid, 1); cyc_end();
    @(negedge clk); set_idle_inputs(); rdy1 = 1; ptr1 = 2'd2; spectag1 = 5'b01000; cyc();
    @(negedge clk); set_idle_inputs(); prsuccess = 1; specfixtag = 5'b01000; cyc();
    @(negedge clk); set_idle_inputs(); prmiss = 1; killspecvec = 5'b11111; cyc_check();
    chk("fix_noabort", ex_abort, 0); cyc_end();
    @(negedge clk); set_idle_inputs(); ex_done = 1; cyc_check();
    chk("fix_done", done_valid, 1); chk("fix_src", done_src, 1); cyc_end();

    // Reset mid-op, then a station-1-only request is granted at once.
    @(negedge clk); set_idle_inputs(); rdy0 = 1; spectag0 = 5'b00001; cyc();
    @(negedge clk); set_idle_inputs(); reset = 1; cyc();
    @(negedge clk); set_idle_inputs(); rdy1 = 1; ptr1 = 2'd1; cyc_check();
    chk("rstmid_inflight", inflight, 0); chk("rstmid_start", ex_start, 1);
    chk("rstmid_exbusy1", exbusy1, 0); chk("rstmid_abort", ex_abort, 0); cyc_end();

    // Randomised traffic, including ex_done while idle and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 99) == 0);
      rdy0        = $urandom_range(0, 1) == 1;
      rdy1        = $urandom_range(0, 1) == 1;
      ptr0        = 2'($urandom);
      ptr1        = 2'($urandom);
      spectag0    = 5'(1 << $urandom_range(0, 4));
      spectag1    = 5'(1 << $urandom_range(0, 4));
      prmiss      = ($urandom_range(0, 7) == 0);
      prsuccess   = ($urandom_range(0, 5) == 0);
      killspecvec = 5'($urandom);
      specfixtag  = 5'(1 << $urandom_range(0, 4));
      ex_done     = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
